seg7_scan_decoder: RTL
======================

// Module: seg7_scan_decoder
// PURPOSE
//  Observes a time-multiplexed 4-digit 7-segment bus (LEDs/active/point, all active-low) and
//  reconstructs the displayed digits as 4-bit codes plus decimal points. It is the receive end of
//  the display-scan interface, used as an on-chip monitor and as the self-checking observer in
//  calculator benches. It emits one registered frame each time all four anodes are captured.
// PARAMETERS
//  STABLE_CYCLES   16         consecutive identical samples required to accept a digit (>=2)
//  TIMEOUT_CYCLES  1_000_000  clocks without any capture before stale asserts
// PORTS
//  clk          in   1   system clock, rising edge
//  rst          in   1   asynchronous, active-high reset
//  LEDs         in   7   segments {a,b,c,d,e,f,g}; bit6=a, bit0=g; 0 = lit
//  active       in   4   anode enables, 0 = on; active[3]=leftmost digit, active[0]=rightmost
//  point        in   1   decimal point, 0 = lit
//  digit3..0    out  4   each: decoded code of anode 3..0 (0-9 digit, 10 blank, 11 minus, 15 invalid)
//  dp           out  4   dp[i]=1 when the point was lit on anode i
//  frame_valid  out  1   one-cycle pulse; digit*/dp/frame_err updated on this cycle
//  frame_err    out  1   1 if any digit of the current frame decoded to 15
//  stale        out  1   1 while no digit captured for TIMEOUT_CYCLES clocks
// BEHAVIOUR
//  Reset (async): digit3..0=4'd10, dp=0, frame_valid=0, frame_err=0, stale=0. Internal state
//   also clears: sample regs, stability counter, armed=1, capture mask=0, shadow regs=10,
//   timeout counter=0. Every output is registered.
//  Sampling: {active,LEDs,point} is registered every clock. A sample counts toward stability only
//   when active has exactly one 0 bit. cnt increments when the current sample equals the previous
//   one; otherwise cnt reloads to 1 (valid anode) or 0 (not one-hot). cnt saturates.
//  Capture: when cnt reaches STABLE_CYCLES and armed=1, the decoded code and point are written into
//   shadow[i] for the low anode i, mask[i] is set, and armed clears. armed sets again only when
//   the sample changes. Each anode dwell therefore produces at most one capture.
//   If the same anode is captured again before the frame completes, shadow[i] is overwritten
//   and the mask is unchanged.
//  Decode (active-low): 0=0000001 1=1001111 2=0010010 3=0000110 4=1001100 5=0100100
//   6=0100000 7=0001111 8=0000000 9=0000100 blank=1111111->10 minus=1111110->11.
//   Any other pattern decodes to 15.
//  Frame: on the edge where a capture makes mask==4'b1111, that capture is merged in and the
//   digit/dp outputs load from the shadow regs on that same edge. frame_err loads the OR of
//   (code==15) over the four digits. frame_valid is high for exactly the following cycle, and
//   mask clears on that edge. Latency is STABLE_CYCLES+1 clocks from the first stable sample on
//   the last anode to frame_valid.
//   Outputs hold between frames.
//  States: IDLE (mask=0), FILLING (0<mask<F), EMIT (frame_valid cycle) -> IDLE. A capture during
//   EMIT is accepted into the fresh frame (mask=bit of that anode).
//  Non-one-hot active (0000, 1100, 1111, ...): ignored, no capture, mask preserved.
//  Stale: tcnt increments each clock without a capture and saturates at TIMEOUT_CYCLES. stale=1
//   while tcnt==TIMEOUT_CYCLES. Any capture clears tcnt and stale on the same edge. Frames
//   already emitted are not invalidated.
//  Reset asserted mid-frame discards partial shadow contents. There is no frame_valid in the
//   cycle after reset release.
// TESTING
//  1 STABLE=16; dwell 20 clk each: a0=3 (0000110), a1=7, a2=1111111, a3=1111111 -> single
//    frame_valid; digit3..0={10,10,7,3}; dp=0; frame_err=0.
//  2 Same scan, a0 dwell 10 clk then a1..a3 20 clk -> no frame. Next full scan -> frame with a0
//    captured.
//  3 a2=1111110 with point=0, a1=0000100, a0=0000001 -> digit2=11, digit1=9, digit0=0,
//    dp=4'b0100.
//  4 a0 LEDs=1010101 -> digit0=15, frame_err=1. The next clean scan -> frame_err=0.
//  5 active=1100 and 1111 for 100 clk between dwells -> no capture, mask unchanged, and the
//    frame still completes.
//  6 TIMEOUT=64, scan stops -> stale=1 at 64 clk after the last capture, clears on the next
//    capture. Assert rst mid-frame -> all outputs at reset values immediately.

Source files
------------

// File: rtl/seg7_scan_decoder.sv
// -----------------------------------------------------------------------------
// seg7_scan_decoder
//
// Receive end of a time-multiplexed 4-digit 7-segment display bus. The bus is
// watched passively: each anode dwell that stays stable long enough is decoded
// into a 4-bit code plus decimal point and stored per anode. Once all four
// anodes have been captured, a registered frame is emitted with a one-cycle
// frame_valid pulse.
//
// Parameters
//   STABLE_CYCLES   consecutive identical samples needed to accept a digit (>=2)
//   TIMEOUT_CYCLES  clocks without any capture before stale asserts
//
// Ports
//   clk          system clock, rising edge
//   rst          asynchronous, active-high reset
//   LEDs[6:0]    segments {a,b,c,d,e,f,g}, active-low (bit6 = a, bit0 = g)
//   active[3:0]  anode enables, active-low (active[3] = leftmost digit)
//   point        decimal point, active-low
//   digit3..0    decoded code per anode: 0-9 digit, 10 blank, 11 minus,
//                15 invalid
//   dp[3:0]      dp[i] = 1 when the point was lit on anode i
//   frame_valid  one-cycle pulse in the cycle the frame outputs change
//   frame_err    1 if any digit of the current frame decoded to 15
//   stale        1 while nothing has been captured for TIMEOUT_CYCLES clocks
// -----------------------------------------------------------------------------
module seg7_scan_decoder #(
    parameter int STABLE_CYCLES  = 16,
    parameter int TIMEOUT_CYCLES = 1_000_000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [6:0] LEDs,
    input  logic [3:0] active,
    input  logic       point,
    output logic [3:0] digit3,
    output logic [3:0] digit2,
    output logic [3:0] digit1,
    output logic [3:0] digit0,
    output logic [3:0] dp,
    output logic       frame_valid,
    output logic       frame_err,
    output logic       stale
);

    localparam int CW = $clog2(STABLE_CYCLES + 1);
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [CW-1:0] CNT_MAX  = CW'(STABLE_CYCLES);
    localparam logic [TW-1:0] TCNT_MAX = TW'(TIMEOUT_CYCLES);

    localparam logic [3:0] CODE_BLANK   = 4'd10;
    localparam logic [3:0] CODE_MINUS   = 4'd11;
    localparam logic [3:0] CODE_INVALID = 4'd15;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        FILLING = 2'd1,
        EMIT    = 2'd2
    } state_t;

    // -------------------------------------------------------------------------
    // Helpers
    // -------------------------------------------------------------------------
    // True when exactly one anode is enabled (exactly one zero bit).
    function automatic logic one_hot_low(input logic [3:0] a);
        logic r;
        case (a)
            4'b1110, 4'b1101, 4'b1011, 4'b0111: r = 1'b1;
            default:                            r = 1'b0;
        endcase
        return r;
    endfunction

    // Active-low segment pattern to display code.
    function automatic logic [3:0] decode_segments(input logic [6:0] seg);
        logic [3:0] code;
        case (seg)
            7'b0000001: code = 4'd0;
            7'b1001111: code = 4'd1;
            7'b0010010: code = 4'd2;
            7'b0000110: code = 4'd3;
            7'b1001100: code = 4'd4;
            7'b0100100: code = 4'd5;
            7'b0100000: code = 4'd6;
            7'b0001111: code = 4'd7;
            7'b0000000: code = 4'd8;
            7'b0000100: code = 4'd9;
            7'b1111111: code = CODE_BLANK;
            7'b1111110: code = CODE_MINUS;
            default:    code = CODE_INVALID;
        endcase
        return code;
    endfunction

    // -------------------------------------------------------------------------
    // State
    // -------------------------------------------------------------------------
    logic [11:0]   sample_next;          // {active, LEDs, point}
    logic [11:0]   sample_reg;
    logic [CW-1:0] cnt_reg;
    logic          armed_reg;
    logic [3:0]    mask_reg;
    logic [3:0]    shadow_code_reg [4];
    logic [3:0]    shadow_dp_reg;
    logic [TW-1:0] tcnt_reg;
    state_t        state_reg;
    logic [3:0]    digit_reg [4];
    logic [3:0]    dp_reg;
    logic          frame_valid_reg;
    logic          frame_err_reg;
    logic          stale_reg;

    // -------------------------------------------------------------------------
    // Combinational capture / merge logic
    // -------------------------------------------------------------------------
    logic          sample_changed;
    logic          next_one_hot;
    logic          capture;
    logic [3:0]    cap_code;
    logic          cap_point_lit;
    logic [3:0]    cap_sel;
    logic [3:0]    merged_code [4];
    logic [3:0]    merged_dp;
    logic [3:0]    merged_bad;
    logic [3:0]    mask_merged;
    logic          frame_done;
    logic [TW-1:0] tcnt_inc;

    assign sample_next    = {active, LEDs, point};
    assign sample_changed = (sample_next != sample_reg);
    assign next_one_hot   = one_hot_low(active);

    // cnt only climbs on a one-hot sample, so reaching CNT_MAX already implies
    // a valid anode is held in sample_reg. armed limits this to one capture
    // per dwell.
    assign capture        = armed_reg && (cnt_reg == CNT_MAX);
    assign cap_code       = decode_segments(sample_reg[7:1]);
    assign cap_point_lit  = ~sample_reg[0];

    generate
        for (genvar gi = 0; gi < 4; gi++) begin : g_merge
            assign cap_sel[gi]     = capture & ~sample_reg[8 + gi];
            // The frame must include the capture happening on this very edge,
            // so the output path sees shadow contents with it merged in.
            assign merged_code[gi] = cap_sel[gi] ? cap_code : shadow_code_reg[gi];
            assign merged_dp[gi]   = cap_sel[gi] ? cap_point_lit : shadow_dp_reg[gi];
            assign merged_bad[gi]  = (merged_code[gi] == CODE_INVALID);
        end
    endgenerate

    assign mask_merged = mask_reg | cap_sel;
    assign frame_done  = capture && (mask_merged == 4'b1111);
    assign tcnt_inc    = (tcnt_reg == TCNT_MAX) ? tcnt_reg : tcnt_reg + TW'(1);

    // -------------------------------------------------------------------------
    // Sampler, stability counter, arming, timeout and frame FSM
    // -------------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sample_reg      <= '0;
            cnt_reg         <= '0;
            armed_reg       <= 1'b1;
            mask_reg        <= 4'b0000;
            tcnt_reg        <= '0;
            stale_reg       <= 1'b0;
            state_reg       <= IDLE;
            frame_valid_reg <= 1'b0;
            frame_err_reg   <= 1'b0;
            dp_reg          <= 4'b0000;
        end else begin
            sample_reg <= sample_next;

            // Stability counter: counts identical consecutive samples of a
            // single enabled anode; anything not one-hot holds it at zero.
            if (sample_changed) begin
                cnt_reg <= next_one_hot ? CW'(1) : '0;
            end else if (next_one_hot && (cnt_reg != CNT_MAX)) begin
                cnt_reg <= cnt_reg + CW'(1);
            end

            // A new sample re-arms even if the old one is captured on this
            // same edge; the new sample is a fresh dwell.
            if (sample_changed) begin
                armed_reg <= 1'b1;
            end else if (capture) begin
                armed_reg <= 1'b0;
            end

            // Timeout tracking.
            if (capture) begin
                tcnt_reg  <= '0;
                stale_reg <= 1'b0;
            end else begin
                tcnt_reg  <= tcnt_inc;
                stale_reg <= (tcnt_inc == TCNT_MAX);
            end

            // Frame assembly.
            case (state_reg)
                IDLE, FILLING: begin
                    if (frame_done) begin
                        mask_reg        <= 4'b0000;
                        state_reg       <= EMIT;
                        frame_valid_reg <= 1'b1;
                        frame_err_reg   <= |merged_bad;
                        dp_reg          <= merged_dp;
                    end else begin
                        frame_valid_reg <= 1'b0;
                        if (capture) begin
                            mask_reg  <= mask_merged;
                            state_reg <= FILLING;
                        end
                    end
                end
                EMIT: begin
                    // mask was cleared on entry, so any capture here starts
                    // the next frame with just this anode.
                    frame_valid_reg <= 1'b0;
                    if (capture) begin
                        mask_reg  <= cap_sel;
                        state_reg <= FILLING;
                    end else begin
                        state_reg <= IDLE;
                    end
                end
                default: begin
                    frame_valid_reg <= 1'b0;
                    mask_reg        <= 4'b0000;
                    state_reg       <= IDLE;
                end
            endcase
        end
    end

    // -------------------------------------------------------------------------
    // Per-anode shadow and output digit registers
    // -------------------------------------------------------------------------
    generate
        for (genvar gi = 0; gi < 4; gi++) begin : g_anode
            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    shadow_code_reg[gi] <= CODE_BLANK;
                    shadow_dp_reg[gi]   <= 1'b0;
                end else if (cap_sel[gi]) begin
                    // A repeat capture of the same anode simply overwrites.
                    shadow_code_reg[gi] <= cap_code;
                    shadow_dp_reg[gi]   <= cap_point_lit;
                end
            end

            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    digit_reg[gi] <= CODE_BLANK;
                end else if (frame_done) begin
                    digit_reg[gi] <= merged_code[gi];
                end
            end
        end
    endgenerate

    assign digit3      = digit_reg[3];
    assign digit2      = digit_reg[2];
    assign digit1      = digit_reg[1];
    assign digit0      = digit_reg[0];
    assign dp          = dp_reg;
    assign frame_valid = frame_valid_reg;
    assign frame_err   = frame_err_reg;
    assign stale       = stale_reg;

endmodule
